// File: rtl/nes_pad_if.sv
// Pad-side bundle of the NES poller: serial data from the pads, shared latch/pulse,
// and the decoded per-pad button levels, press events and frame strobe.
interface nes_pad_if #(
    parameter int NUM_PADS = 1
);
    logic [NUM_PADS-1:0]   data_in;
    logic                  latch;
    logic                  pulse;
    logic [8*NUM_PADS-1:0] buttons;
    logic [8*NUM_PADS-1:0] pressed;
    logic                  frame_valid;
    logic                  busy;

    modport master (
        input  data_in,
        output latch, pulse, buttons, pressed, frame_valid, busy
    );

    modport slave (
        output data_in,
        input  latch, pulse, buttons, pressed, frame_valid, busy
    );
endinterface

// File: rtl/nes_pad_poller.sv
// NES controller poller: periodic latch/pulse sequence shared by all pads, 8-bit capture
// per pad, held levels plus one-cycle press events with optional auto-repeat.
module nes_pad_poller #(
    parameter int CLK_HZ        = 50000000,
    parameter int POLL_HZ       = 60,
    parameter int LATCH_CYC     = 600,
    parameter int GAP_CYC       = 300,
    parameter int HALF_CYC      = 300,
    parameter int NUM_PADS      = 1,
    parameter int REPEAT_FRAMES = 0
) (
    input  logic     clk,
    input  logic     reset,
    nes_pad_if.master pad
);
    localparam int PERIOD = CLK_HZ / POLL_HZ;
    localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int MAXC   = (LATCH_CYC > GAP_CYC) ? ((LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC)
                                                  : ((GAP_CYC > HALF_CYC) ? GAP_CYC : HALF_CYC);
    localparam int PHW    = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int NB     = 8 * NUM_PADS;

    generate
        if (LATCH_CYC + GAP_CYC + 16 * HALF_CYC + 1 >= PERIOD) begin : g_bad_period
            $error("nes_pad_poller: frame does not fit in poll period");
        end
        if (LATCH_CYC < 1 || GAP_CYC < 1 || HALF_CYC < 1) begin : g_bad_width
            $error("nes_pad_poller: phase widths must be at least one cycle");
        end
        if ($bits(pad.buttons) != NB) begin : g_bad_if
            $error("nes_pad_poller: interface NUM_PADS does not match module");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_GAP,
        S_HI,
        S_LO,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  per_q, per_d;
    logic [PHW-1:0] cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic           tick;
    logic           capture;

    logic           latch_q, latch_d;
    logic           pulse_q, pulse_d;
    logic           busy_q, busy_d;
    logic           fv_q, fv_d;
    logic [NB-1:0]  buttons_q, buttons_d;
    logic [NB-1:0]  pressed_q, pressed_d;
    logic [NB-1:0]  shift_vec;
    logic [NB-1:0]  press_vec;

    always_comb begin
        per_d = (per_q == PW'(PERIOD - 1)) ? '0 : per_q + PW'(1);
        tick  = (per_q == PW'(PERIOD - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (tick) state_d = S_LATCH;
            end
            S_LATCH: begin
                if (cnt_q == PHW'(LATCH_CYC - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PHW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == PHW'(GAP_CYC - 1)) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + PHW'(1);
                end
            end
            S_HI: begin
                if (cnt_q == PHW'(HALF_CYC - 1)) begin
                    state_d = S_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PHW'(1);
                end
            end
            S_LO: begin
                if (cnt_q == PHW'(HALF_CYC - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HI;
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + PHW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Each bit is sampled on the edge that raises pulse for it; bit_d is its index.
    always_comb begin
        capture   = (state_d == S_HI) && (state_q != S_HI);
        latch_d   = (state_d == S_LATCH);
        pulse_d   = (state_d == S_HI);
        busy_d    = (state_d != S_IDLE);
        fv_d      = (state_d == S_DONE);
        buttons_d = fv_d ? shift_vec : buttons_q;
        pressed_d = fv_d ? press_vec : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            per_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            fv_q      <= 1'b0;
            buttons_q <= '0;
            pressed_q <= '0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            fv_q      <= fv_d;
            buttons_q <= buttons_d;
            pressed_q <= pressed_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
            logic       meta_q, meta_d;
            logic       sync_q, sync_d;
            logic [7:0] sr_q, sr_d;

            always_comb begin
                meta_d = pad.data_in[gi];
                sync_d = meta_q;
                sr_d   = sr_q;
                if (capture) sr_d[bit_d] = ~sync_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                    sr_q   <= '0;
                end else begin
                    meta_q <= meta_d;
                    sync_q <= sync_d;
                    sr_q   <= sr_d;
                end
            end

            assign shift_vec[8*gi +: 8] = sr_q;
        end

        for (gi = 0; gi < NB; gi++) begin : g_bit
            logic cur_b, old_b, press_d;
            assign cur_b = shift_vec[gi];
            assign old_b = buttons_q[gi];

            if (REPEAT_FRAMES > 0) begin : g_rep
                localparam int HW = $clog2(REPEAT_FRAMES + 1);
                logic [HW-1:0] hold_q, hold_d;

                // Counter tracks frames held since the last reported event.
                always_comb begin
                    press_d = 1'b0;
                    hold_d  = hold_q;
                    if (fv_d) begin
                        if (!cur_b) begin
                            hold_d = '0;
                        end else if (!old_b) begin
                            press_d = 1'b1;
                            hold_d  = '0;
                        end else if (hold_q == HW'(REPEAT_FRAMES - 1)) begin
                            press_d = 1'b1;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                end

                always_ff @(posedge clk) begin
                    if (reset) hold_q <= '0;
                    else       hold_q <= hold_d;
                end
            end else begin : g_edge
                always_comb press_d = cur_b && !old_b;
            end

            assign press_vec[gi] = press_d;
        end
    endgenerate

    assign pad.latch       = latch_q;
    assign pad.pulse       = pulse_q;
    assign pad.busy        = busy_q;
    assign pad.frame_valid = fv_q;
    assign pad.buttons     = buttons_q;
    assign pad.pressed     = pressed_q;
endmodule
